// File: rtl/mac_pair_sched.sv
// ============================================================================
//  Module   : mac_pair_sched
//  Brief    : Operand scheduler for the 4-bit MAC. Buffers operand streams A
//             and B in small FIFOs, pairs them in arrival order and issues
//             framed bursts of cfg_len products with first/last markers, then
//             waits for the MAC result. Optional WAIT timeout is enabled by
//             defining MAC_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_pair_sched #(
    parameter int DW         = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_LEN    = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] in_a,
    input  logic          in_valid_a,
    output logic          ready_a,
    input  logic [DW-1:0] in_b,
    input  logic          in_valid_b,
    output logic          ready_b,
    input  logic [3:0]    cfg_len,
    input  logic          start,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic          op_valid,
    output logic          op_first,
    output logic          op_last,
    input  logic          mac_valid,
    output logic          busy,
    output logic          frame_done,
    output logic          err_len,
    output logic          err_timeout
);

    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam logic [3:0] c_max_len = 4'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Reset is asserted asynchronously but released in step with clk.
    logic [1:0] r_rst_pipe;
    logic       w_rst_n;

    // Two-flop reset release synchroniser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_pipe <= 2'b00;
        else          r_rst_pipe <= {r_rst_pipe[0], 1'b1};
    end
    assign w_rst_n = r_rst_pipe[1];

    // ------------------------------------------------------------------
    // Operand FIFOs: pointers carry one wrap bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [DW-1:0] r_mem_a [FIFO_DEPTH];
    logic [DW-1:0] r_mem_b [FIFO_DEPTH];
    logic [AW:0]   r_wp_a, r_rp_a, r_wp_b, r_rp_b;
    logic          w_full_a, w_full_b, w_empty_a, w_empty_b;
    logic          w_push_a, w_push_b, w_pop;

    state_t        r_state;
    logic [3:0]    r_len;
    logic [3:0]    r_cnt;
    logic [DW-1:0] r_op_a, r_op_b;
    logic          r_op_valid, r_op_first, r_op_last;
    logic          w_to_hit;

    assign w_full_a  = (r_wp_a[AW] != r_rp_a[AW]) && (r_wp_a[AW-1:0] == r_rp_a[AW-1:0]);
    assign w_full_b  = (r_wp_b[AW] != r_rp_b[AW]) && (r_wp_b[AW-1:0] == r_rp_b[AW-1:0]);
    assign w_empty_a = (r_wp_a == r_rp_a);
    assign w_empty_b = (r_wp_b == r_rp_b);
    assign w_push_a  = in_valid_a && !w_full_a;
    assign w_push_b  = in_valid_b && !w_full_b;
    assign w_pop     = (r_state == S_RUN) && !w_empty_a && !w_empty_b;

    // FIFO storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push_a) r_mem_a[r_wp_a[AW-1:0]] <= in_a;
        if (w_push_b) r_mem_b[r_wp_b[AW-1:0]] <= in_b;
    end

    // FIFO pointer bookkeeping; pushes are accepted in every state.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wp_a <= '0;
            r_rp_a <= '0;
            r_wp_b <= '0;
            r_rp_b <= '0;
        end else begin
            if (w_push_a) r_wp_a <= r_wp_a + (AW+1)'(1);
            if (w_push_b) r_wp_b <= r_wp_b + (AW+1)'(1);
            if (w_pop) begin
                r_rp_a <= r_rp_a + (AW+1)'(1);
                r_rp_b <= r_rp_b + (AW+1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional WAIT watchdog.
    // ------------------------------------------------------------------
`ifdef MAC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_to_cnt;

    // Counts cycles spent in WAIT; zero on the first WAIT cycle.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)                r_to_cnt <= '0;
        else if (r_state != S_WAIT)  r_to_cnt <= '0;
        else                         r_to_cnt <= r_to_cnt + TW'(1);
    end

    assign w_to_hit    = (r_state == S_WAIT) && (r_to_cnt == TW'(TIMEOUT - 1));
    // A MAC answer in the limit cycle takes priority over the timeout.
    assign err_timeout = w_to_hit && !mac_valid;
`else
    assign w_to_hit    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Frame sequencer.
    // ------------------------------------------------------------------
    // IDLE -> RUN on legal start, issue len pairs, WAIT for the MAC result.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_valid <= 1'b0;
            r_op_first <= 1'b0;
            r_op_last  <= 1'b0;
        end else begin
            r_op_valid <= 1'b0;
            r_op_first <= 1'b0;
            r_op_last  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && (cfg_len != 4'd0) && (cfg_len <= c_max_len)) begin
                        r_len   <= cfg_len;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_pop) begin
                        r_op_a     <= r_mem_a[r_rp_a[AW-1:0]];
                        r_op_b     <= r_mem_b[r_rp_b[AW-1:0]];
                        r_op_valid <= 1'b1;
                        r_op_first <= (r_cnt == 4'd0);
                        r_op_last  <= (r_cnt == r_len - 4'd1);
                        r_cnt      <= r_cnt + 4'd1;
                        if (r_cnt == r_len - 4'd1) r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mac_valid || w_to_hit) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_a    = !w_full_a;
    assign ready_b    = !w_full_b;
    assign op_a       = r_op_a;
    assign op_b       = r_op_b;
    assign op_valid   = r_op_valid;
    assign op_first   = r_op_first;
    assign op_last    = r_op_last;
    assign busy       = (r_state != S_IDLE);
    // Pulses while the FSM is still in WAIT, so a start this cycle is ignored.
    assign frame_done = (r_state == S_WAIT) && mac_valid;
    assign err_len    = (r_state == S_IDLE) && start &&
                        ((cfg_len == 4'd0) || (cfg_len > c_max_len));

endmodule

`default_nettype wire
